// File: rtl/bram_write_arbiter.sv
// Two-requester BRAM write arbiter: accepts one wide result vector at a time and
// streams it into BRAM one narrow word per cycle, lowest word first.
module bram_write_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 13,
    parameter int unsigned DATA_IN_WIDTH  = 512,
    parameter int unsigned DATA_OUT_WIDTH = 32,
    parameter int unsigned BASE_ADDR_0    = 5,
    parameter int unsigned BASE_ADDR_1    = 21
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [1:0]                valid_i,
    input  logic [DATA_IN_WIDTH-1:0]  data0_i,
    input  logic [DATA_IN_WIDTH-1:0]  data1_i,
    output logic [1:0]                ready_o,
    output logic [1:0]                done_o,
    output logic                      busy_o,
    output logic [ADDRESS_WIDTH-1:0]  bram_addr,
    output logic [DATA_OUT_WIDTH-1:0] bram_din,
    output logic                      bram_en,
    output logic                      bram_we
);

    localparam int unsigned N     = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0]         LAST_WORD = CNT_W'(N - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BASE0     = ADDRESS_WIDTH'(BASE_ADDR_0);
    localparam logic [ADDRESS_WIDTH-1:0] BASE1     = ADDRESS_WIDTH'(BASE_ADDR_1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic                     last_grant_q;
    logic                     grant_q;
    logic [DATA_IN_WIDTH-1:0] shreg_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     wr_en_q;
    logic [1:0]               done_q;
    logic                     busy_q;
    logic                     handshake;
    logic                     grant_sel;

    // Ready is combinational so a requester can hand off in the same cycle;
    // gated by reset so it reads zero while reset is held.
    always_comb begin
        ready_o = 2'b00;
        if (rst_i && (state_q == S_IDLE) && en_i) begin
            case (valid_i)
                2'b01:   ready_o = 2'b01;
                2'b10:   ready_o = 2'b10;
                default: ready_o = last_grant_q ? 2'b01 : 2'b10;
            endcase
        end
    end

    assign handshake = |(valid_i & ready_o);
    assign grant_sel = ready_o[1];

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (handshake) state_d = S_WRITE;
            S_WRITE: if (cnt_q == LAST_WORD) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: the shift register empties itself over N zero-filled shifts, so
    // its low word reads zero everywhere outside WRITE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            shreg_q      <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            done_q       <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        grant_q      <= grant_sel;
                        last_grant_q <= grant_sel;
                        shreg_q      <= grant_sel ? data1_i : data0_i;
                        addr_q       <= grant_sel ? BASE1 : BASE0;
                        cnt_q        <= '0;
                        wr_en_q      <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_WRITE: begin
                    shreg_q <= shreg_q >> DATA_OUT_WIDTH;
                    addr_q  <= addr_q + ADDRESS_WIDTH'(1);
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        wr_en_q <= 1'b0;
                        done_q  <= grant_q ? 2'b10 : 2'b01;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    busy_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bram_addr = addr_q;
    assign bram_din  = shreg_q[DATA_OUT_WIDTH-1:0];
    assign bram_en   = wr_en_q;
    assign bram_we   = wr_en_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;

endmodule

// File: doc/bram_write_arbiter.md
BRAM_WRITE_ARBITER -- requirements
Module: bram_write_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 13: BRAM word-address width.
REQ-002 Parameter DATA_IN_WIDTH, default 512: width of one result vector per requester.
REQ-003 Parameter DATA_OUT_WIDTH, default 32: BRAM data-port width; DATA_IN_WIDTH SHALL be an integer multiple of it, giving N = DATA_IN_WIDTH/DATA_OUT_WIDTH (16 by default).
REQ-004 Parameter BASE_ADDR_0, default 5: first BRAM address for requester 0.
REQ-005 Parameter BASE_ADDR_1, default 21: first BRAM address for requester 1.
REQ-006 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_i  input  1  reset; asynchronous, active-low.
REQ-008 en_i  input  1  grant enable; low blocks new grants.
REQ-009 valid_i  input  2  per-requester result-available flag; bit n belongs to requester n.
REQ-010 data0_i, data1_i  input  DATA_IN_WIDTH each  result vectors of requesters 0 and 1.
REQ-011 ready_o  output  2  per-requester accept flag; handshake on valid_i[n] & ready_o[n].
REQ-012 done_o  output  2  one-cycle pulse when requester n's vector is fully written.
REQ-013 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-014 bram_addr  output  ADDRESS_WIDTH  BRAM write address.
REQ-015 bram_din  output  DATA_OUT_WIDTH  BRAM write data.
REQ-016 bram_en, bram_we  output  1 each  BRAM port enable and write enable.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE, DONE; reset state IDLE.
REQ-018 In IDLE with en_i=1, exactly one ready_o bit SHALL be high: the bit for the single valid requester, or with both valid the bit not equal to last_grant; with neither valid, the bit not equal to last_grant.
REQ-019 In IDLE with en_i=0, and in WRITE and DONE, ready_o SHALL be 2'b00.
REQ-020 On handshake, the block SHALL register the selected data into a shift register, set grant and last_grant to n, load the address counter with BASE_ADDR_n, clear the word counter, and move to WRITE next cycle.
REQ-021 In WRITE, each cycle SHALL drive bram_en=1, bram_we=1, bram_din = low DATA_OUT_WIDTH bits of the shift register, and bram_addr = current address; the shift register then shifts right by DATA_OUT_WIDTH (zero fill), and address and word counter increment.
REQ-022 WRITE SHALL last exactly N cycles, writing word k (bits k*DATA_OUT_WIDTH upward) to BASE_ADDR_n + k, k = 0..N-1, lowest word first.
REQ-023 The address SHALL wrap modulo 2^ADDRESS_WIDTH without error.
REQ-024 After word N-1 the FSM SHALL enter DONE for one cycle with done_o[grant]=1, bram_en=0, bram_we=0, then return to IDLE.
REQ-025 Handshake-to-done latency SHALL be N+1 cycles; back-to-back requests SHALL be accepted no sooner than the cycle after DONE (IDLE re-entry).
REQ-026 Outside WRITE, bram_en, bram_we SHALL be 0 and bram_din SHALL be 0.
REQ-027 en_i deasserted during WRITE or DONE SHALL NOT abort the transfer; it only blocks the next grant.
REQ-028 valid_i changes or data changes after the handshake SHALL NOT affect the transfer in progress.
REQ-029 busy_o SHALL be high in WRITE and DONE, low in IDLE.

Reset
REQ-030 rst_i low SHALL, at any time, force state IDLE, last_grant=1 (requester 0 wins the first tie), ready_o=0, done_o=0, busy_o=0, bram_en=0, bram_we=0, bram_din=0, bram_addr=0, shift register and counters 0.
REQ-031 Reset mid-WRITE SHALL discard the transfer; no done_o pulse SHALL follow for it.

Verification
REQ-032 Single request: valid_i=01, data0_i word k = k+1 -> bram_addr 5..20 get 1..16 on 16 consecutive cycles, done_o=01 on the 17th cycle after handshake.
REQ-033 Tie: valid_i=11 after reset -> requester 0 granted first (addr 5..20), then requester 1 (addr 21..36), done_o pulses 01 then 10.
REQ-034 Fairness: valid_i held 11 for 4 transfers -> grants alternate 0,1,0,1.
REQ-035 Wrap: BASE_ADDR_0=8186, ADDRESS_WIDTH=13 -> addresses 8186..8191, then 0..9.
REQ-036 en_i=0 in IDLE with valid_i=01 -> ready_o=00, no BRAM writes; en_i dropped mid-WRITE -> all 16 words still written, done_o pulses.
REQ-037 rst_i low at WRITE word 7 -> all outputs 0 asynchronously, no done_o; after release, new request starts at its base address.
